// File: rtl/mem_arbiter.sv
// Two-master (I-cache / D-cache) line arbiter in front of a single memory port.
// Define ARB_FAIR_EN for round-robin tie breaking; otherwise the D-side wins ties.
module mem_arbiter #(
   parameter int WORD_SIZE = 16,
   parameter int LINE_BITS = 64,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_req,
   input  logic [WORD_SIZE-1:0] i_addr,
   output logic                 i_done,
   output logic [LINE_BITS-1:0] i_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [LINE_BITS-1:0] d_wdata,
   output logic                 d_done,
   output logic [LINE_BITS-1:0] d_rdata,
   output logic                 m_req,
   output logic                 m_we,
   output logic [WORD_SIZE-1:0] m_addr,
   output logic [LINE_BITS-1:0] m_wdata,
   input  logic [LINE_BITS-1:0] m_rdata,
   input  logic                 m_ack,
   output logic                 err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   state_t               state_q, state_d;
   logic                 owner_q, owner_d;   // 1 = D-side owns the current/last transaction
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic                 we_q, we_d;
   logic [LINE_BITS-1:0] wdata_q, wdata_d;
   logic [CW-1:0]        wait_q, wait_d;
   logic                 err_q, err_d;
   logic [LINE_BITS-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_BITS-1:0] d_rdata_q, d_rdata_d;
   logic                 pick_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         wait_q    <= '0;
         err_q     <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         wait_q    <= wait_d;
         err_q     <= err_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      wait_d    = wait_q;
      err_d     = err_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      pick_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
`ifdef ARB_FAIR_EN
               // On a tie, serve whoever was not served last.
               pick_d = d_req && (!i_req || !owner_q);
`else
               pick_d = d_req;
`endif
               state_d = pick_d ? BUSY_D : BUSY_I;
               owner_d = pick_d;
               addr_d  = (pick_d ? d_addr : i_addr) & ~WORD_SIZE'(3);
               we_d    = pick_d & d_we;
               wdata_d = d_wdata;
               wait_d  = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (m_ack) begin
               state_d = DONE;
               if (state_q == BUSY_I)
                  i_rdata_d = m_rdata;
               else if (!we_q)
                  d_rdata_d = m_rdata;
            end else if (wait_q == CW'(TIMEOUT - 1)) begin
               // Give up: complete to the owner with stale data and flag it.
               state_d = DONE;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign m_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
   assign m_we    = (state_q == BUSY_D) && we_q;
   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign i_done  = (state_q == DONE) && !owner_q;
   assign d_done  = (state_q == DONE) && owner_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign err     = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WORD_SIZE, 16, address width; LINE_BITS, 64, cache-line data width (4 words); TIMEOUT, 255, maximum memory-ack wait in cycles.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 i_req  input  1  I-cache line-fill request; held high until i_done.
REQ-005 i_addr  input  WORD_SIZE  I-cache miss address.
REQ-006 i_done  output  1  one-cycle completion pulse to the I-cache.
REQ-007 i_rdata  output  LINE_BITS  fill line for the I-cache; valid when i_done=1.
REQ-008 d_req  input  1  D-cache request; held high until d_done.
REQ-009 d_we  input  1  1 = write-back of a line, 0 = line fill.
REQ-010 d_addr  input  WORD_SIZE  D-cache address.
REQ-011 d_wdata  input  LINE_BITS  write-back line.
REQ-012 d_done  output  1  one-cycle completion pulse to the D-cache.
REQ-013 d_rdata  output  LINE_BITS  fill line for the D-cache; valid when d_done=1.
REQ-014 m_req  output  1  memory request, held until m_ack.
REQ-015 m_we  output  1  memory write enable.
REQ-016 m_addr  output  WORD_SIZE  line-aligned memory address.
REQ-017 m_wdata  output  LINE_BITS  memory write line.
REQ-018 m_rdata  input  LINE_BITS  memory read line; valid with m_ack.
REQ-019 m_ack  input  1  one-cycle memory completion.
REQ-020 err  output  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have four states: IDLE, BUSY_I, BUSY_D and DONE.
REQ-022 In IDLE with only i_req=1, the FSM SHALL go to BUSY_I; with only d_req=1, it SHALL go to BUSY_D; with neither, it SHALL stay in IDLE.
REQ-023 With i_req=d_req=1 in IDLE, the block SHALL select the winner per REQ-036/REQ-037.
REQ-024 On leaving IDLE, the block SHALL latch the address, d_we and d_wdata; m_addr SHALL equal the latched address with bits [1:0] forced to 0.
REQ-025 m_req SHALL be high, from the registered output, in every BUSY cycle and low in all other states; the first m_req cycle SHALL be the cycle after the request is sampled.
REQ-026 m_we SHALL be 1 only in BUSY_D with latched d_we=1; in BUSY_I, m_we SHALL be 0.
REQ-027 On m_ack=1 in a BUSY state, the block SHALL register m_rdata into the owner's rdata register and go to DONE.
REQ-028 In DONE, the block SHALL pulse the owner's done signal for exactly one cycle, then return to IDLE.
REQ-029 The block SHALL NOT sample a new request in the DONE cycle.
REQ-030 The block SHALL hold i_rdata/d_rdata until the next fill for the same requester; they SHALL be ignored for write-backs, and d_rdata SHALL NOT change on a write-back.
REQ-031 If the requester drops its req mid-transaction, the transaction SHALL still complete and done SHALL still pulse.
REQ-032 The block SHALL ignore m_ack outside BUSY states.
REQ-033 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without m_ack.
REQ-034 On reaching TIMEOUT, the block SHALL go to DONE, pulse the owner's done, leave the rdata register unchanged, and set err; err SHALL stay set until reset.

Reset
REQ-035 While reset=1 at a clock edge, the block SHALL set the state to IDLE and clear m_req, m_we, i_done, d_done, err, the wait counter and the rdata registers to 0; m_addr/m_wdata SHALL read as 0. A transaction in flight at reset SHALL be abandoned, with no done pulse, and m_req SHALL be low the cycle after reset is sampled.

Configuration
REQ-036 ARB_FAIR_EN defined: the block SHALL use round-robin arbitration. A last-owner bit SHALL be set on each grant; a simultaneous request SHALL go to the requester not served last; last-owner SHALL reset to I, so D wins the first tie.
REQ-037 ARB_FAIR_EN undefined: the D-side SHALL always win ties (fixed priority), and the block SHALL contain no last-owner register.

Verification
REQ-038 d_req=1, d_we=0, d_addr=16'h0013; m_ack after 3 cycles with m_rdata=64'h0001_0002_0003_0004 -> m_addr=16'h0010, m_we=0, d_done pulses once with d_rdata=64'h0001_0002_0003_0004, i_done stays 0.
REQ-039 i_req and d_req rise in the same cycle -> D is served first in both builds; the I fill follows, starting 2 cycles after d_done.
REQ-040 ARB_FAIR_EN build, three back-to-back ties -> grant order D, I, D; without the macro -> D, D, D while d_req stays high.
REQ-041 d_we=1, d_wdata=64'hDEAD_BEEF_CAFE_F00D -> m_we=1 and m_wdata matches for every m_req cycle; d_rdata is unchanged.
REQ-042 No m_ack for 255 BUSY cycles -> owner's done pulses, err=1 and stays 1; a subsequent request is still served.
REQ-043 reset asserted in the 2nd BUSY cycle -> the cycle after, m_req=0, no done pulse, err=0, state IDLE.
